freq_measure_sequencer: RTL and testbench

//   Measurement sequencer for the frequency counter. Opens a gate window of a

---
 rtl/freq_measure_sequencer.sv | 86 ++++++++
 tb/tb_freq_measure_sequencer.sv | 89 ++++++++
 2 files changed

// File: rtl/freq_measure_sequencer.sv
// freq_measure_sequencer: gate window edge counter with BCD conversion handshake and display load
module freq_measure_sequencer #(
  parameter int BITS           = 12,
  parameter int DEFAULT_PERIOD = 11999,
  parameter int MAX_COUNT      = 99,
  parameter int CONV_TIMEOUT   = 31
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            edge_pulse,
  input  logic [BITS-1:0] period_in,
  input  logic            period_load,
  input  logic            conv_done,
  output logic            conv_start,
  output logic [6:0]      conv_count,
  output logic            disp_load,
  output logic            gate_open,
  output logic            overrange,
  output logic            conv_error
);
  localparam int TW = $clog2(CONV_TIMEOUT + 1);
  typedef enum logic [1:0] {GATE, CONVERT, LOAD} state_t;
  state_t          state_q;
  logic [BITS-1:0] sample_q, period_q, pending_q, pending_d;
  logic [6:0]      edges_q, edges_d;
  logic [TW-1:0]   wait_q;
  logic            done_ok, timeout, enter_gate;
  always_comb begin
    edges_d    = (edge_pulse && edges_q != 7'(MAX_COUNT + 1)) ? edges_q + 7'd1 : edges_q;
    pending_d  = (period_load && period_in != '0) ? period_in : pending_q;
    done_ok    = state_q == CONVERT && wait_q != '0 && conv_done;
    timeout    = state_q == CONVERT && !done_ok && wait_q == TW'(CONV_TIMEOUT);
    enter_gate = state_q == LOAD || timeout;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GATE;
      sample_q   <= '0;
      edges_q    <= '0;
      period_q   <= BITS'(DEFAULT_PERIOD);
      pending_q  <= BITS'(DEFAULT_PERIOD);
      wait_q     <= '0;
      conv_start <= 1'b0;
      conv_count <= '0;
      disp_load  <= 1'b0;
      gate_open  <= 1'b1;
      overrange  <= 1'b0;
      conv_error <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      conv_start <= 1'b0;
      disp_load  <= 1'b0;
      case (state_q)
        GATE: begin
          edges_q  <= edges_d;
          sample_q <= sample_q + BITS'(1);
          if (sample_q == period_q) begin
            state_q    <= CONVERT;
            gate_open  <= 1'b0;
            conv_start <= 1'b1;
            conv_count <= (edges_d > 7'(MAX_COUNT)) ? 7'(MAX_COUNT) : edges_d;
            wait_q     <= '0;
          end
        end
        CONVERT: begin
          wait_q <= wait_q + TW'(1);
          if (done_ok) begin
            state_q   <= LOAD;
            disp_load <= 1'b1;
            overrange <= edges_q > 7'(MAX_COUNT);
          end
          if (timeout) conv_error <= 1'b1;
        end
        default: ;
      endcase
      // the window length is latched only as a new gate opens
      if (enter_gate) begin
        state_q   <= GATE;
        gate_open <= 1'b1;
        sample_q  <= '0;
        edges_q   <= '0;
        period_q  <= pending_d;
      end
    end
  end
endmodule

// File: tb/tb_freq_measure_sequencer.sv
// tb_freq_measure_sequencer: random stimulus checked against a timestamp-based window model
module tb_freq_measure_sequencer;
  localparam int DEF = 19;
  logic        clk = 1'b0, reset, edge_pulse, period_load, conv_done;
  logic [11:0] period_in;
  logic        conv_start, disp_load, gate_open, overrange, conv_error;
  logic [6:0]  conv_count;
  int n_tests = 0, n_fail = 0;
  int c, ws, plen, cnt, cs, dl, cc, pend;
  bit err, ovr;
  freq_measure_sequencer #(.BITS(12), .DEFAULT_PERIOD(DEF), .MAX_COUNT(99), .CONV_TIMEOUT(31)) dut (
    .clk(clk), .reset(reset), .edge_pulse(edge_pulse), .period_in(period_in),
    .period_load(period_load), .conv_done(conv_done), .conv_start(conv_start),
    .conv_count(conv_count), .disp_load(disp_load), .gate_open(gate_open),
    .overrange(overrange), .conv_error(conv_error));
  always #5 clk = ~clk;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, c, got, exp);
    end
  endtask
  task automatic model_reset(int at);
    ws = at; plen = DEF + 1; cnt = 0; cs = -1000; dl = -1; cc = 0; pend = DEF; err = 0; ovr = 0;
  endtask
  task automatic model_step(bit rst, bit e, bit d, bit pl, int pin);
    int np;
    bit gating;
    np = (pl && pin != 0) ? pin : pend;
    gating = c < ws + plen;
    if (rst) begin
      model_reset(c + 1);
    end else begin
      if (gating) begin
        if (e) cnt++;
        if (c == ws + plen - 1) begin
          cs = c + 1;
          cc = cnt > 99 ? 99 : cnt;
        end
      end else if (c == dl) begin
        ws = c + 1; plen = np + 1; cnt = 0; dl = -1;
      end else if (c > cs && d) begin
        dl = c + 1;
        ovr = cnt > 99;
      end else if (c == cs + 31) begin
        err = 1; ws = c + 1; plen = np + 1; cnt = 0;
      end
      pend = np;
    end
  endtask
  initial begin
    int ep, dp, r, pin;
    bit gating, loading, rst;
    reset = 1; edge_pulse = 0; period_load = 0; conv_done = 0; period_in = '0;
    @(posedge clk); #1;
    reset = 0;
    c = 0;
    model_reset(0);
    ep = 50; dp = 100;
    repeat (20000) begin
      gating  = c < ws + plen;
      loading = c == dl;
      check("gate_open", 32'(gate_open), 32'(gating));
      check("conv_start", 32'(conv_start), 32'(c == cs));
      check("disp_load", 32'(disp_load), 32'(loading));
      check("overrange", 32'(overrange), 32'(ovr));
      check("conv_error", 32'(conv_error), 32'(err));
      if (!gating && !loading) check("conv_count", 32'(conv_count), 32'(cc));
      if (c % 64 == 0) begin
        r = $urandom_range(2); ep = r == 0 ? 10 : r == 1 ? 50 : 90;
        r = $urandom_range(2); dp = r == 0 ? 0 : r == 1 ? 15 : 100;
      end
      r = $urandom_range(9);
      pin = r == 0 ? 0 : r == 1 ? 199 : $urandom_range(30, 5);
      rst = $urandom_range(999) < 3;
      reset       = rst;
      edge_pulse  = $urandom_range(99) < ep;
      conv_done   = $urandom_range(99) < dp;
      period_load = $urandom_range(99) < 4;
      period_in   = 12'(pin);
      model_step(rst, edge_pulse, conv_done, period_load, pin);
      @(posedge clk); #1;
      c++;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
